// File: rtl/mem_pkg.sv
// Shared definitions for the register-file memory and its request controller.
//   MEM_DATA_W : default memory data width
//   MEM_ADDR_W : default memory address width (4 entries)
//   LAT_CNT_W  : width of the read-latency counter (covers RD_LAT up to 7)
//   mem_ctrl_state_t : controller state encoding
package mem_pkg;

   localparam int unsigned MEM_DATA_W = 8;
   localparam int unsigned MEM_ADDR_W = 2;
   localparam int unsigned LAT_CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RWAIT,
      RESP
   } mem_ctrl_state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Initiator-side controller for the synchronous register-file memory.
// Accepts one read or write request at a time over a valid/ready handshake.
// It drives the memory strobes, addresses and write data, and waits out the
// read latency. Read data is returned over a valid/ready response channel.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   request fields, sampled only at accept
//   rsp_valid/rsp_ready           read response handshake
//   rsp_rdata                     read data, stable while rsp_valid is high
//   mem_wr, mem_rd                memory strobes, one cycle each
//   mem_waddr, mem_raddr, mem_din memory address/data pins, held when unused
//   mem_dout                      memory read data
module mem_req_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = MEM_DATA_W,
   parameter int unsigned ADDR_W = MEM_ADDR_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
      $error("mem_req_ctrl: RD_LAT must be in 1..7");
   end

   mem_ctrl_state_t        state, state_nxt;
   logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_nxt;
   logic                   mem_wr_nxt, mem_rd_nxt, rsp_valid_nxt;
   logic [ADDR_W-1:0]      mem_waddr_nxt, mem_raddr_nxt;
   logic [DATA_W-1:0]      mem_din_nxt, rsp_rdata_nxt;

   // The state register is reset asynchronously, so req_ready is low while
   // rst is high.
   assign req_ready = (state == IDLE) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         mem_wr    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_waddr <= '0;
         mem_raddr <= '0;
         mem_din   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state     <= state_nxt;
         lat_cnt   <= lat_cnt_nxt;
         mem_wr    <= mem_wr_nxt;
         mem_rd    <= mem_rd_nxt;
         mem_waddr <= mem_waddr_nxt;
         mem_raddr <= mem_raddr_nxt;
         mem_din   <= mem_din_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      lat_cnt_nxt   = lat_cnt;
      mem_wr_nxt    = mem_wr;
      mem_rd_nxt    = mem_rd;
      mem_waddr_nxt = mem_waddr;
      mem_raddr_nxt = mem_raddr;
      mem_din_nxt   = mem_din;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;

      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_we) begin
                  mem_waddr_nxt = req_addr;
                  mem_din_nxt   = req_wdata;
                  mem_wr_nxt    = 1'b1;
                  state_nxt     = WRITE;
               end else begin
                  mem_raddr_nxt = req_addr;
                  mem_rd_nxt    = 1'b1;
                  lat_cnt_nxt   = LAT_CNT_W'(RD_LAT);
                  state_nxt     = RWAIT;
               end
            end
         end

         WRITE: begin
            mem_wr_nxt = 1'b0;
            state_nxt  = IDLE;
         end

         RWAIT: begin
            mem_rd_nxt = 1'b0;
            // The counter reaches zero after RD_LAT cycles. The memory
            // has sampled mem_rd by then and mem_dout is valid, so the
            // capture lands RD_LAT+1 cycles after accept. An RD_LAT of 7
            // still fits in the 3-bit counter.
            if (lat_cnt == '0) begin
               rsp_rdata_nxt = mem_dout;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               lat_cnt_nxt = lat_cnt - LAT_CNT_W'(1);
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
